apb_master_bridge: RTL
======================

# apb_master_bridge

Upstream APB requester for the peripheral subsystem. It accepts single-beat read/write requests on a valid/ready port and drives the APB4 setup and access phases to the GPIO and UART slaves. It decodes the address to one of two slave slots, handles wait states, and returns read data and an error flag as a one-cycle response. Illegal addresses and hung slaves complete with an error instead of stalling the requester.

## Interface
Parameters:
- DATAWIDTH, 32, APB data width
- ADDRWIDTH, 32, APB address width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before forced termination; 0 disables the timeout

Ports:
- PCLK  in  1  single clock; all logic is on its rising edge
- PRESET  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts a request
- req_addr  in  ADDRWIDTH  byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  DATAWIDTH  write data
- req_strb  in  4  byte strobes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATAWIDTH  read data; 0 for writes and errors
- rsp_err  out  1  PSLVERR, decode error or timeout
- PSEL  out  2  one-hot slave select: bit0 = GPIO, bit1 = UART
- PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDRWIDTH  APB address
- PWDATA  out  DATAWIDTH  APB write data
- PSTRB  out  4  APB strobes
- PRDATA0, PRDATA1  in  DATAWIDTH  slave read data
- PREADY0, PREADY1  in  1  slave ready
- PSLVERR0, PSLVERR1  in  1  slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- req_ready = (state == IDLE). A request is accepted on a PCLK edge with req_valid && req_ready.
- Address decode on req_addr:
  - addr[ADDRWIDTH-1:13] must be 0; otherwise decode error.
  - addr[12] selects the slot: 0 = GPIO, 1 = UART.
- IDLE, on accept:
  - Capture addr, write, wdata and strb.
  - Strobes are forced to 4'b0000 when req_write = 0.
  - Decode OK: go to SETUP. Decode error: go to DONE with err = 1; no PSEL is ever asserted.
- SETUP: selected PSEL bit = 1, PENABLE = 0; PADDR/PWRITE/PWDATA/PSTRB driven from the captured values. Unconditionally go to ACCESS.
- ACCESS:
  - PENABLE = 1; PSEL and all payload signals held stable.
  - The ready, error and read-data inputs of the selected slot are muxed; the other slot is ignored.
  - On PREADY = 1: capture PRDATA (reads only; 0 for writes) and PSLVERR, then go to DONE.
  - Timeout counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entering ACCESS and increments each ACCESS cycle without PREADY.
  - When TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES: go to DONE with err = 1, rdata = 0.
  - PREADY in the same cycle as expiry takes priority: normal completion.
- DONE: rsp_valid = 1 for exactly one cycle, PSEL = 0, PENABLE = 0, then go to IDLE. rsp_rdata/rsp_err are valid only while rsp_valid = 1; they hold their value otherwise.
- PADDR/PWDATA/PWRITE/PSTRB keep their last values outside a transfer.
- No response backpressure; the requester must sample rsp_valid.

## Timing
- Reset values (asynchronous, immediate on PRESET):
  - state = IDLE, so req_ready = 1 once reset deasserts; req_ready = 0 while PRESET is high.
  - PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, PSTRB = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, timeout counter = 0.
- Zero-wait transfer, request accepted at edge E0:
  - PSEL high after E0; PENABLE high after E1.
  - PREADY sampled at E2; rsp_valid high after E2; req_ready high again after E3.
  - Throughput is 4 cycles per transfer; each PREADY-low cycle adds 1.
- Decode error: accepted at E0, rsp_valid high after E0, back in IDLE after E1.
- Timeout: rsp_valid rises the cycle after the TIMEOUT_CYCLES-th non-ready ACCESS cycle.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, no rsp_valid is generated, and the transfer is lost.
- APB rule: PSEL never changes between SETUP and the completing ACCESS cycle; PENABLE is never high without PSEL.

## Structure
- Shared package apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/DONE);
  - slot indices GPIO_SLOT = 0, UART_SLOT = 1;
  - address-map constants SLOT_SEL_BIT = 12 and DECODE_MSB_LO = 13;
  - the data_register_address / control_register_address values shared with the GPIO bench.
- One sub-module, apb_addr_decode: purely combinational, req_addr -> {slot one-hot, decode_err}. It is reused by future slaves added to the map.
- FSM, capture registers, timeout counter and response mux live in apb_master_bridge.

## Test plan
- Write GPIO control register: addr 0x0000_0001, wdata 1, strb 4'b0001, PREADY0 tied 1 -> PSEL = 2'b01 for 2 cycles with PENABLE in the second; PSTRB = 4'b0001; rsp_valid 3 cycles after accept; rsp_err = 0.
- Read UART: addr 0x0000_1000, PREADY1 low for 3 ACCESS cycles, PRDATA1 = 0x0000_00A5 -> ACCESS lasts 4 cycles; PSEL = 2'b10 throughout; PSTRB = 0 even with req_strb = 4'b1111; rsp_rdata = 0xA5.
- Decode error: addr 0x0000_2000 -> PSEL stays 0; rsp_valid the cycle after accept with rsp_err = 1 and rsp_rdata = 0.
- Timeout: TIMEOUT_CYCLES = 16, PREADY0 held 0 -> PENABLE high for exactly 16 cycles, then PSEL drops and rsp_err = 1. Repeat with PREADY0 rising on the 16th cycle -> normal completion, rsp_err = 0.
- Slave error: GPIO returns PSLVERR0 = 1 with PREADY0 on a write with strb 4'b0000 -> rsp_err = 1. The next back-to-back request is accepted exactly 1 cycle after rsp_valid.
- Reset in ACCESS: assert PRESET mid-wait -> PSEL/PENABLE = 0 immediately, no rsp_valid; after release, req_ready = 1 and a GPIO data write of 0x100 completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge and its address decoder.
// Holds the bridge FSM encoding, slot indices, address-map constants and
// the GPIO register addresses shared with the GPIO bench.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_SLOTS     = 2;
  localparam int unsigned GPIO_SLOT     = 0;
  localparam int unsigned UART_SLOT     = 1;

  // Address map: bit 12 picks the slot, bits [ADDRWIDTH-1:13] must be zero.
  localparam int unsigned SLOT_SEL_BIT  = 12;
  localparam int unsigned DECODE_MSB_LO = 13;

  localparam logic [31:0] DATA_REGISTER_ADDRESS    = 32'h0000_0000;
  localparam logic [31:0] CONTROL_REGISTER_ADDRESS = 32'h0000_0001;

  // Reads never carry byte strobes on the bus.
  function automatic logic [3:0] apb_strobe(input logic write, input logic [3:0] strb);
    return write ? strb : 4'b0000;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder for the APB slot map.
// Ports:
//   req_addr   in  byte address
//   slot       out one-hot slot select (bit0 = GPIO, bit1 = UART), 0 on error
//   decode_err out address falls outside the mapped window
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 32
) (
  input  logic [ADDRWIDTH-1:0] req_addr,
  output logic [NUM_SLOTS-1:0] slot,
  output logic                 decode_err
);

  // Address shifted down to the slot-select bit; everything above bit 0 of
  // this value is the region that must be zero.
  logic [ADDRWIDTH-1:0] upper;

  assign upper = req_addr >> SLOT_SEL_BIT;

  // Decode error and one-hot slot select.
  always_comb begin
    decode_err       = |(upper >> (DECODE_MSB_LO - SLOT_SEL_BIT));
    slot             = '0;
    slot[GPIO_SLOT]  = !decode_err && !upper[0];
    slot[UART_SLOT]  = !decode_err &&  upper[0];
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-beat valid/ready request port to APB4 master for the GPIO and UART
// slaves. Decodes the slot, runs SETUP/ACCESS with wait states and an
// optional access timeout, and returns a one-cycle response pulse.
// Ports:
//   PCLK, PRESET                 clock, async active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_addr/write/wdata/strb    request payload
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion with data and error
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB  APB master outputs
//   PRDATAx/PREADYx/PSLVERRx     per-slot APB slave returns
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned DATAWIDTH      = 32,
  parameter int unsigned ADDRWIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic                 req_write,
  input  logic [DATAWIDTH-1:0] req_wdata,
  input  logic [3:0]           req_strb,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [1:0]           PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  output logic [3:0]           PSTRB,
  input  logic [DATAWIDTH-1:0] PRDATA0,
  input  logic [DATAWIDTH-1:0] PRDATA1,
  input  logic                 PREADY0,
  input  logic                 PREADY1,
  input  logic                 PSLVERR0,
  input  logic                 PSLVERR1
);

  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t               state, state_nxt;
  logic [1:0]           psel_nxt;
  logic                 penable_nxt, pwrite_nxt;
  logic [ADDRWIDTH-1:0] paddr_nxt;
  logic [DATAWIDTH-1:0] pwdata_nxt;
  logic [3:0]           pstrb_nxt;
  logic                 rsp_valid_nxt, rsp_err_nxt;
  logic [DATAWIDTH-1:0] rsp_rdata_nxt;
  logic [TCNT_W-1:0]    tcnt, tcnt_nxt, tcnt_inc;
  logic                 timeout_hit;

  logic [1:0]           dec_slot;
  logic                 dec_err;
  logic                 sel_ready, sel_err;
  logic [DATAWIDTH-1:0] sel_rdata;

  apb_addr_decode #(.ADDRWIDTH(ADDRWIDTH)) u_addr_decode (
    .req_addr   (req_addr),
    .slot       (dec_slot),
    .decode_err (dec_err)
  );

  // Ready follows IDLE but is held low while reset is asserted.
  assign req_ready = (state == IDLE) && !PRESET;

  // Return-path mux: only the selected slot's signals are observed.
  always_comb begin
    if (PSEL[UART_SLOT]) begin
      sel_ready = PREADY1;
      sel_err   = PSLVERR1;
      sel_rdata = PRDATA1;
    end else begin
      sel_ready = PREADY0;
      sel_err   = PSLVERR0;
      sel_rdata = PRDATA0;
    end
  end

  assign tcnt_inc    = tcnt + TCNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_inc == TCNT_W'(TIMEOUT_CYCLES));

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    psel_nxt      = 2'b00;
    penable_nxt   = 1'b0;
    pwrite_nxt    = PWRITE;
    paddr_nxt     = PADDR;
    pwdata_nxt    = PWDATA;
    pstrb_nxt     = PSTRB;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    tcnt_nxt      = tcnt;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (dec_err) begin
            // Bus stays untouched; complete straight away with an error.
            state_nxt     = DONE;
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = '0;
            rsp_err_nxt   = 1'b1;
          end else begin
            state_nxt  = SETUP;
            psel_nxt   = dec_slot;
            paddr_nxt  = req_addr;
            pwrite_nxt = req_write;
            pwdata_nxt = req_wdata;
            pstrb_nxt  = apb_strobe(req_write, req_strb);
          end
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        psel_nxt    = PSEL;
        penable_nxt = 1'b1;
        tcnt_nxt    = '0;
      end
      ACCESS: begin
        if (sel_ready) begin
          // Ready wins over a timeout expiring in the same cycle.
          state_nxt     = DONE;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = PWRITE ? '0 : sel_rdata;
          rsp_err_nxt   = sel_err;
        end else if (timeout_hit) begin
          state_nxt     = DONE;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
          tcnt_nxt      = tcnt_inc;
        end else begin
          psel_nxt    = PSEL;
          penable_nxt = 1'b1;
          tcnt_nxt    = tcnt_inc;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= 2'b00;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      tcnt      <= '0;
    end else begin
      state     <= state_nxt;
      PSEL      <= psel_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      PSTRB     <= pstrb_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      tcnt      <= tcnt_nxt;
    end
  end

endmodule
